// File: rtl/ddr2pe_ctrl.sv
// ddr2pe_ctrl: walks the PE groups for one layer-load command, launching the
// index-buffer and data-buffer loaders per group and waiting for both to finish.
module ddr2pe_ctrl #(
   parameter int unsigned PE_NUM    = 32,
   parameter int unsigned IDX_DEPTH = 256,
   parameter int unsigned BUF_DEPTH = 256,
   localparam int unsigned G   = PE_NUM / 4,
   localparam int unsigned GNW = $clog2(G + 1),
   localparam int unsigned GW  = (G > 1) ? $clog2(G) : 1,
   localparam int unsigned IW  = $clog2(IDX_DEPTH),
   localparam int unsigned PW  = $clog2(BUF_DEPTH)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [1:0]     mode,
   input  logic [GNW-1:0] grp_num,
   input  logic [IW-1:0]  idx_num,
   input  logic [7:0]     ch_num,
   input  logic [3:0]     row_num,
   input  logic [PW-1:0]  pix_num,
   output logic           busy,
   output logic           done,
   output logic [G-1:0]   wr_sel,
   output logic           ibuf_start,
   output logic           dbuf_start,
   input  logic           ibuf_done,
   input  logic           dbuf_done,
   output logic [1:0]     ld_mode,
   output logic [IW-1:0]  ld_idx_num,
   output logic [7:0]     ld_ch_num,
   output logic [3:0]     ld_row_num,
   output logic [PW-1:0]  ld_pix_num
);

   typedef enum logic [1:0] {StIdle, StLaunch, StWait, StFin} state_e;

   state_e         state_q, state_d;
   logic [GW-1:0]  g_q, g_d;
   logic           fi_q, fi_d;
   logic           fd_q, fd_d;
   logic           latch;

   logic [GNW-1:0] grp_q;
   logic [GNW-1:0] grp_clamped;
   logic [1:0]     mode_q;
   logic [IW-1:0]  idx_q;
   logic [7:0]     ch_q;
   logic [3:0]     row_q;
   logic [PW-1:0]  pix_q;

   // Registered outputs, computed from the next state so they line up with it
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           launch_q, launch_d;
   logic [G-1:0]   sel_q, sel_d;

   // Requests beyond the PE array are clamped to the full group count
   always_comb begin
      grp_clamped = grp_num;
      if (grp_num > GNW'(G)) begin
         grp_clamped = GNW'(G);
      end
   end

   // Next-state, group counter, done flags and registered-output next values
   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      fi_d    = fi_q;
      fd_d    = fd_q;
      latch   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               latch = 1'b1;
               g_d   = '0;
               if (grp_clamped == '0) begin
                  state_d = StFin;
               end else begin
                  state_d = StLaunch;
               end
            end
         end
         StLaunch: begin
            // Fresh flags for this group; a zero-latency done is still captured
            fi_d    = ibuf_done;
            fd_d    = dbuf_done;
            state_d = StWait;
         end
         StWait: begin
            fi_d = fi_q | ibuf_done;
            fd_d = fd_q | dbuf_done;
            if (fi_d && fd_d) begin
               if (GNW'(g_q) == grp_q - GNW'(1)) begin
                  state_d = StFin;
               end else begin
                  g_d     = g_q + GW'(1);
                  state_d = StLaunch;
               end
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      busy_d   = (state_d != StIdle);
      done_d   = (state_d == StFin);
      launch_d = (state_d == StLaunch);
      sel_d    = '0;
      if (state_d == StLaunch || state_d == StWait) begin
         sel_d = G'(1) << g_d;
      end
   end

   // FSM state, group counter and per-group done flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         g_q     <= '0;
         fi_q    <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         fi_q    <= fi_d;
         fd_q    <= fd_d;
      end
   end

   // Command registers, loaded only when a start is accepted in idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grp_q  <= '0;
         mode_q <= '0;
         idx_q  <= '0;
         ch_q   <= '0;
         row_q  <= '0;
         pix_q  <= '0;
      end else if (latch) begin
         grp_q  <= grp_clamped;
         mode_q <= mode;
         idx_q  <= idx_num;
         ch_q   <= ch_num;
         row_q  <= row_num;
         pix_q  <= pix_num;
      end
   end

   // Output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         launch_q <= 1'b0;
         sel_q    <= '0;
      end else begin
         busy_q   <= busy_d;
         done_q   <= done_d;
         launch_q <= launch_d;
         sel_q    <= sel_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign ibuf_start = launch_q;
   assign dbuf_start = launch_q;
   assign wr_sel     = sel_q;
   assign ld_mode    = mode_q;
   assign ld_idx_num = idx_q;
   assign ld_ch_num  = ch_q;
   assign ld_row_num = row_q;
   assign ld_pix_num = pix_q;

endmodule

// File: tb/tb_ddr2pe_ctrl.sv
// Scoreboard bench for ddr2pe_ctrl: a timeline model predicts every launch and
// done event per command; a monitor pops and compares as the DUT presents them.
module tb_ddr2pe_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] mode = '0;
   logic [3:0] grp_num = '0;
   logic [7:0] idx_num = '0;
   logic [7:0] ch_num = '0;
   logic [3:0] row_num = '0;
   logic [7:0] pix_num = '0;
   logic       busy, done, ibuf_start, dbuf_start;
   logic       ibuf_done = 1'b0;
   logic       dbuf_done = 1'b0;
   logic [7:0] wr_sel;
   logic [1:0] ld_mode;
   logic [7:0] ld_idx_num, ld_ch_num, ld_pix_num;
   logic [3:0] ld_row_num;

   ddr2pe_ctrl #(.PE_NUM(32), .IDX_DEPTH(256), .BUF_DEPTH(256)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .grp_num(grp_num),
      .idx_num(idx_num), .ch_num(ch_num), .row_num(row_num), .pix_num(pix_num),
      .busy(busy), .done(done), .wr_sel(wr_sel), .ibuf_start(ibuf_start),
      .dbuf_start(dbuf_start), .ibuf_done(ibuf_done), .dbuf_done(dbuf_done),
      .ld_mode(ld_mode), .ld_idx_num(ld_idx_num), .ld_ch_num(ld_ch_num),
      .ld_row_num(ld_row_num), .ld_pix_num(ld_pix_num)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         is_done;
      int         cyc;
      logic [7:0] sel;
      logic [1:0] mode;
      logic [7:0] idx;
      logic [7:0] ch;
      logic [3:0] row;
      logic [7:0] pix;
   } exp_t;

   exp_t exp_q[$];
   int   lat_i_q[$];
   int   lat_d_q[$];
   int   stray_req = 0;
   int   stray_ack = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Loader model: answers each start after the latency queued for it
   initial begin
      int  cnt_i, cnt_d;
      bit  pend_i, pend_d;
      cnt_i = 0; cnt_d = 0; pend_i = 0; pend_d = 0;
      forever begin
         @(negedge clk);
         ibuf_done = 1'b0;
         dbuf_done = 1'b0;
         if (rst) begin
            pend_i = 0;
            pend_d = 0;
            lat_i_q.delete();
            lat_d_q.delete();
         end else begin
            if (ibuf_start && lat_i_q.size() > 0) begin
               cnt_i = lat_i_q.pop_front();
               pend_i = 1;
            end
            if (dbuf_start && lat_d_q.size() > 0) begin
               cnt_d = lat_d_q.pop_front();
               pend_d = 1;
            end
            if (pend_i) begin
               if (cnt_i == 0) begin ibuf_done = 1'b1; pend_i = 0; end
               else cnt_i--;
            end
            if (pend_d) begin
               if (cnt_d == 0) begin dbuf_done = 1'b1; pend_d = 0; end
               else cnt_d--;
            end
            if (stray_req != stray_ack) begin
               ibuf_done = 1'b1;
               stray_ack++;
            end
         end
      end
   end

   // Monitor: compares every launch/done event against the scoreboard
   initial begin
      bit         prev_busy;
      logic [7:0] prev_sel;
      exp_t       e;
      prev_busy = 0;
      prev_sel  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            prev_busy = 0;
         end else begin
            if (ibuf_start || dbuf_start || done) begin
               chk("event_expected", 32'(exp_q.size() > 0), 32'(1));
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("event_cycle", 32'(cyc), 32'(e.cyc));
                  chk("event_kind_done", 32'(done), 32'(e.is_done));
                  chk("busy_at_event", 32'(busy), 32'(1));
                  if (!e.is_done) begin
                     chk("ibuf_start", 32'(ibuf_start), 32'(1));
                     chk("dbuf_start", 32'(dbuf_start), 32'(1));
                     chk("wr_sel_launch", 32'(wr_sel), 32'(e.sel));
                     chk("ld_mode", 32'(ld_mode), 32'(e.mode));
                     chk("ld_idx_num", 32'(ld_idx_num), 32'(e.idx));
                     chk("ld_ch_num", 32'(ld_ch_num), 32'(e.ch));
                     chk("ld_row_num", 32'(ld_row_num), 32'(e.row));
                     chk("ld_pix_num", 32'(ld_pix_num), 32'(e.pix));
                  end else begin
                     chk("no_start_at_done", 32'(ibuf_start | dbuf_start), 32'(0));
                     chk("wr_sel_at_done", 32'(wr_sel), 32'(0));
                  end
               end
            end else if (exp_q.size() > 0) begin
               chk("event_not_overdue", 32'(exp_q[0].cyc > cyc), 32'(1));
               if (exp_q[0].cyc <= cyc) void'(exp_q.pop_front());
            end
            if (!busy) chk("wr_sel_idle", 32'(wr_sel), 32'(0));
            if (busy && prev_busy && !ibuf_start && !done)
               chk("wr_sel_hold", 32'(wr_sel), 32'(prev_sel));
            prev_busy = busy;
            prev_sel  = wr_sel;
         end
      end
   end

   // Build the expected timeline for one command and pulse start (called at a negedge)
   task automatic issue_cmd(input logic [1:0] m, input logic [3:0] gn, input logic [7:0] idx,
                            input logic [7:0] ch, input logic [3:0] row, input logic [7:0] pix,
                            input int li_fix, input int ld_fix,
                            output int end_c, output int l2_c);
      int   n, l, li, ld, mx;
      exp_t e;
      n    = (gn > 4'd8) ? 8 : int'(gn);
      l    = cyc + 1;
      l2_c = -1;
      for (int g = 0; g < n; g++) begin
         li = (li_fix < 0) ? int'($urandom_range(0, 6)) : li_fix;
         ld = (ld_fix < 0) ? int'($urandom_range(0, 6)) : ld_fix;
         lat_i_q.push_back(li);
         lat_d_q.push_back(ld);
         e.is_done = 0; e.cyc = l; e.sel = 8'(1 << g);
         e.mode = m; e.idx = idx; e.ch = ch; e.row = row; e.pix = pix;
         exp_q.push_back(e);
         if (g == 2) l2_c = l;
         mx = (li > ld) ? li : ld;
         if (mx < 1) mx = 1;
         l = l + mx + 1;
      end
      e.is_done = 1; e.cyc = l; e.sel = '0;
      exp_q.push_back(e);
      end_c = l;
      start = 1'b1; mode = m; grp_num = gn; idx_num = idx;
      ch_num = ch; row_num = row; pix_num = pix;
      @(negedge clk);
      start   = 1'b0;
      mode    = 2'($urandom);
      grp_num = 4'($urandom);
      idx_num = 8'($urandom);
      ch_num  = 8'($urandom);
      row_num = 4'($urandom);
      pix_num = 8'($urandom);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic check_outputs_zero();
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_wr_sel", 32'(wr_sel), 32'(0));
      chk("rst_ibuf_start", 32'(ibuf_start), 32'(0));
      chk("rst_dbuf_start", 32'(dbuf_start), 32'(0));
      chk("rst_ld_mode", 32'(ld_mode), 32'(0));
      chk("rst_ld_idx_num", 32'(ld_idx_num), 32'(0));
      chk("rst_ld_ch_num", 32'(ld_ch_num), 32'(0));
      chk("rst_ld_row_num", 32'(ld_row_num), 32'(0));
      chk("rst_ld_pix_num", 32'(ld_pix_num), 32'(0));
   endtask

   task automatic run_cmd(input logic [1:0] m, input logic [3:0] gn, input logic [7:0] idx,
                          input int li, input int ld);
      int end_c, l2_c;
      issue_cmd(m, gn, idx, 8'($urandom), 4'($urandom), 8'($urandom), li, ld, end_c, l2_c);
      wait_until(end_c + 1);
      chk("busy_after_fin", 32'(busy), 32'(0));
      @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int end_c, l2_c, l0_c;
      repeat (3) @(negedge clk);
      check_outputs_zero();
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic load: 3 groups, loaders answer after 10 / 20 cycles
      run_cmd(2'd1, 4'd3, 8'd40, 10, 20);
      // Same-cycle dones, zero-latency dones, either order
      run_cmd(2'd2, 4'd2, 8'd7, 3, 3);
      run_cmd(2'd3, 4'd2, 8'd9, 0, 0);
      run_cmd(2'd0, 4'd3, 8'd1, 1, 5);
      run_cmd(2'd1, 4'd3, 8'd2, 5, 1);
      run_cmd(2'd2, 4'd2, 8'd3, 0, 2);
      // Group-count edges: none, all, clamped
      run_cmd(2'd1, 4'd0, 8'd5, -1, -1);
      run_cmd(2'd2, 4'd8, 8'd6, -1, -1);
      run_cmd(2'd3, 4'd15, 8'd8, -1, -1);

      // Start pulses in WAIT and in FIN must be ignored
      issue_cmd(2'd2, 4'd2, 8'd77, 8'd33, 4'd5, 8'd99, 4, 6, end_c, l2_c);
      l0_c = cyc;
      @(negedge clk);
      start = 1'b1; grp_num = 4'd5; mode = 2'd1; idx_num = 8'd3;
      @(negedge clk);
      start = 1'b0;
      wait_until(end_c);
      start = 1'b1; grp_num = 4'd4; mode = 2'd0; idx_num = 8'd11;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_fin", 32'(busy), 32'(0));
      repeat (3) @(negedge clk);
      chk("ignored_start_busy", 32'(busy), 32'(0));
      chk("latched_mode_kept", 32'(ld_mode), 32'(2));
      chk("latched_idx_kept", 32'(ld_idx_num), 32'(77));
      chk("latched_ch_kept", 32'(ld_ch_num), 32'(33));
      chk("wait_inject_was_after_launch", 32'(l0_c < end_c), 32'(1));

      // Stray done in idle must not satisfy the next command
      stray_req++;
      repeat (3) @(negedge clk);
      run_cmd(2'd1, 4'd1, 8'd12, 4, 3);

      // Randomized commands
      for (int k = 0; k < 20; k++) begin
         run_cmd(2'($urandom), 4'($urandom), 8'($urandom), -1, -1);
      end

      // Asynchronous reset during WAIT of group 2
      issue_cmd(2'd3, 4'd4, 8'd50, 8'd4, 4'd2, 8'd60, 5, 5, end_c, l2_c);
      wait_until(l2_c + 2);
      chk("busy_before_reset", 32'(busy), 32'(1));
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_outputs_zero();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      run_cmd(2'd1, 4'd1, 8'd21, -1, -1);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
